dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter in front of a single-ported data memory.
// Revision 1.0 - initial release.
`default_nettype none

module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DM_ADDRESS-1:0] addr0,
  input  logic [DM_ADDRESS-1:0] addr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_W-1:0]     rdata0,
  output logic [DATA_W-1:0]     rdata1,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_mis;
  logic [DM_ADDRESS-1:0] r_addr;
  logic [DATA_W-1:0]     r_wd;
  logic [2:0]            r_f3;
  logic [DATA_W-1:0]     r_rdata0;
  logic [DATA_W-1:0]     r_rdata1;

  logic                  w_idle;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_sel_we;
  logic [DM_ADDRESS-1:0] w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wd;
  logic [2:0]            w_sel_f3;
  logic                  w_sel_mis;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    m = 1'b0;
    if (f3 == 3'b010)
      m = (a != 2'b00);
    else if (f3 == 3'b001 || f3 == 3'b101)
      m = a[0];
    return m;
  endfunction

  // Contention goes to the port that did not win last; reset_n gates the grant so it reads 0 in reset.
  assign w_idle = (r_state == IDLE) && reset_n;
  assign w_gnt0 = w_idle && req0 && (!req1 || r_last);
  assign w_gnt1 = w_idle && req1 && !w_gnt0;

  assign w_sel_we   = w_gnt1 ? we1      : we0;
  assign w_sel_addr = w_gnt1 ? addr1    : addr0;
  assign w_sel_wd   = w_gnt1 ? wdata1   : wdata0;
  assign w_sel_f3   = w_gnt1 ? funct3_1 : funct3_0;
  assign w_sel_mis  = misaligned(w_sel_f3, w_sel_addr[1:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_mis    <= 1'b0;
      r_addr   <= '0;
      r_wd     <= '0;
      r_f3     <= 3'b000;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner <= w_gnt1;
            r_last  <= w_gnt1;
            r_we    <= w_sel_we;
            r_mis   <= w_sel_mis;
            r_addr  <= w_sel_addr;
            r_wd    <= w_sel_wd;
            r_f3    <= w_sel_f3;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data is valid at the end of the strobe cycle; land it straight in the owner's register.
          if (!r_we && !r_mis) begin
            if (r_owner)
              r_rdata1 <= mem_rd;
            else
              r_rdata0 <= mem_rd;
          end
          r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0       = w_gnt0;
  assign gnt1       = w_gnt1;
  assign busy       = (r_state != IDLE);
  assign mem_read   = (r_state == ISSUE) && !r_we && !r_mis;
  assign mem_write  = (r_state == ISSUE) &&  r_we && !r_mis;
  assign mem_a      = r_addr;
  assign mem_wd     = r_wd;
  assign mem_funct3 = r_f3;
  assign done0      = (r_state == DONE) && !r_owner;
  assign done1      = (r_state == DONE) &&  r_owner;
  assign err0       = done0 && r_mis;
  assign err1       = done1 && r_mis;
  assign rdata0     = r_rdata0;
  assign rdata1     = r_rdata1;

endmodule

`default_nettype wire
